// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module : game_pkg
//  Shared sequencer codes, level selects and referee FSM state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
package game_pkg;

    localparam logic [3:0] GS_START = 4'd0;
    localparam logic [3:0] GS_PREP  = 4'd1;
    localparam logic [3:0] GS_PLAY  = 4'd2;
    localparam logic [3:0] GS_WIN   = 4'd3;

    localparam logic [1:0] LVL_0 = 2'd0;
    localparam logic [1:0] LVL_1 = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PLAY        = 2'd1,
        ST_REPORT_WIN  = 2'd2,
        ST_REPORT_LOSE = 2'd3
    } referee_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
//  Module : edge_rise
//  Rising-edge detector with registered history and synchronous clear.
//  Rev    : 1.0  initial release
// ============================================================================
module edge_rise (
    input  logic pixel_clk,
    input  logic reset,
    input  logic clear,
    input  logic d,
    output logic rise
);

    logic r_hist;

    always_ff @(posedge pixel_clk) begin
        if (reset || clear) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= d;
        end
    end

    assign rise = d & ~r_hist;

endmodule : edge_rise
`default_nettype wire

// File: rtl/level_referee.sv
`default_nettype none
// ============================================================================
//  Module : level_referee
//  Level timer, item/score tracking and win/lose reporting to the sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
module level_referee
    import game_pkg::*;
#(
    parameter int unsigned TIME_W   = 10,
    parameter int unsigned L0_TIME  = 600,
    parameter int unsigned L1_TIME  = 900,
    parameter int unsigned L0_ITEMS = 3,
    parameter int unsigned L1_ITEMS = 5,
    parameter int unsigned ITEM_W   = 4,
    parameter int unsigned SCORE_W  = 16,
    parameter int unsigned ITEM_PTS = 10
) (
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic [3:0]         game_state,
    input  logic [1:0]         selector_value,
    input  logic               frame_tick,
    input  logic               reached_goal,
    input  logic               hit_hazard,
    input  logic               collect_item,
    output logic               win_the_game,
    output logic               lose_the_game,
    output logic [TIME_W-1:0]  time_left,
    output logic [ITEM_W-1:0]  items,
    output logic [SCORE_W-1:0] score
);

    localparam logic [TIME_W-1:0]  c_L0_TIME  = TIME_W'(L0_TIME);
    localparam logic [TIME_W-1:0]  c_L1_TIME  = TIME_W'(L1_TIME);
    localparam logic [ITEM_W-1:0]  c_L0_ITEMS = ITEM_W'(L0_ITEMS);
    localparam logic [ITEM_W-1:0]  c_L1_ITEMS = ITEM_W'(L1_ITEMS);
    localparam logic [SCORE_W:0]   c_ITEM_PTS = (SCORE_W+1)'(ITEM_PTS);

    referee_state_t     r_state, w_state_nx;
    logic [TIME_W-1:0]  r_time,  w_time_nx;
    logic [ITEM_W-1:0]  r_items, w_items_nx;
    logic [SCORE_W-1:0] r_score, w_score_nx;
    logic [SCORE_W-1:0] r_snap,  w_snap_nx;
    logic               r_win,   w_win_nx;
    logic               r_lose,  w_lose_nx;

    logic               w_collect_rise;
    logic               w_is_prep;
    logic               w_level0;
    logic [ITEM_W-1:0]  w_items_req;
    logic [TIME_W-1:0]  w_time_budget;
    logic [TIME_W-1:0]  w_time_dec;
    logic [ITEM_W-1:0]  w_items_inc;
    logic [SCORE_W:0]   w_score_item_sum;
    logic [SCORE_W:0]   w_score_bonus_sum;
    logic [SCORE_W-1:0] w_score_item;
    logic [SCORE_W-1:0] w_score_bonus;

    assign w_is_prep = (game_state == GS_PREP);

    edge_rise u_collect_edge (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .clear     (w_is_prep),
        .d         (collect_item),
        .rise      (w_collect_rise)
    );

    // Selector codes 2 and 3 fall through to level 1
    assign w_level0      = (selector_value == LVL_0);
    assign w_items_req   = w_level0 ? c_L0_ITEMS : c_L1_ITEMS;
    assign w_time_budget = w_level0 ? c_L0_TIME  : c_L1_TIME;

    assign w_time_dec  = (frame_tick && (r_time != '0)) ? (r_time - 1'b1) : r_time;
    assign w_items_inc = (r_items == '1) ? r_items : (r_items + 1'b1);

    // One extra bit catches the carry out for saturation
    assign w_score_item_sum  = {1'b0, r_score} + c_ITEM_PTS;
    assign w_score_bonus_sum = {1'b0, r_score} + (SCORE_W+1)'(r_time);
    assign w_score_item  = w_score_item_sum[SCORE_W]  ? '1 : w_score_item_sum[SCORE_W-1:0];
    assign w_score_bonus = w_score_bonus_sum[SCORE_W] ? '1 : w_score_bonus_sum[SCORE_W-1:0];

    always_comb begin
        w_state_nx = r_state;
        w_time_nx  = r_time;
        w_items_nx = r_items;
        w_score_nx = r_score;
        w_snap_nx  = r_snap;
        w_win_nx   = r_win;
        w_lose_nx  = r_lose;

        if (game_state == GS_START) begin
            w_score_nx = '0;
            w_snap_nx  = '0;
            w_items_nx = '0;
            w_win_nx   = 1'b0;
            w_lose_nx  = 1'b0;
            w_state_nx = ST_IDLE;
        end else if (w_is_prep) begin
            w_time_nx  = w_time_budget;
            w_items_nx = '0;
            w_snap_nx  = r_score;
            w_win_nx   = 1'b0;
            w_lose_nx  = 1'b0;
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (game_state == GS_PLAY) begin
                        w_state_nx = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (game_state == GS_PLAY) begin
                        if (hit_hazard || (r_time == '0)) begin
                            w_lose_nx  = 1'b1;
                            w_score_nx = r_snap;
                            w_state_nx = ST_REPORT_LOSE;
                        end else if (reached_goal && (r_items >= w_items_req)) begin
                            w_win_nx   = 1'b1;
                            w_score_nx = w_score_bonus;
                            w_state_nx = ST_REPORT_WIN;
                        end else begin
                            w_time_nx = w_time_dec;
                            if (w_collect_rise) begin
                                w_items_nx = w_items_inc;
                                w_score_nx = w_score_item;
                            end
                        end
                    end
                end
                ST_REPORT_WIN: begin
                    if (game_state != GS_PLAY) begin
                        w_win_nx   = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_REPORT_LOSE: begin
                    if (game_state != GS_PLAY) begin
                        w_lose_nx  = 1'b0;
                        w_state_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_time  <= '0;
            r_items <= '0;
            r_score <= '0;
            r_snap  <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_time  <= w_time_nx;
            r_items <= w_items_nx;
            r_score <= w_score_nx;
            r_snap  <= w_snap_nx;
            r_win   <= w_win_nx;
            r_lose  <= w_lose_nx;
        end
    end

    assign win_the_game  = r_win;
    assign lose_the_game = r_lose;
    assign time_left     = r_time;
    assign items         = r_items;
    assign score         = r_score;

endmodule : level_referee
`default_nettype wire

// File: tb/tb_level_referee.sv
`default_nettype none
// ============================================================================
//  Module : tb_level_referee
//  Directed self-checking bench for level_referee.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_level_referee;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic [3:0]  game_state;
    logic [1:0]  selector_value;
    logic        frame_tick;
    logic        reached_goal;
    logic        hit_hazard;
    logic        collect_item;
    logic        win_the_game;
    logic        lose_the_game;
    logic [9:0]  time_left;
    logic [3:0]  items;
    logic [15:0] score;

    int r_checks = 0;
    int r_errors = 0;

    level_referee u_dut (
        .pixel_clk      (pixel_clk),
        .reset          (reset),
        .game_state     (game_state),
        .selector_value (selector_value),
        .frame_tick     (frame_tick),
        .reached_goal   (reached_goal),
        .hit_hazard     (hit_hazard),
        .collect_item   (collect_item),
        .win_the_game   (win_the_game),
        .lose_the_game  (lose_the_game),
        .time_left      (time_left),
        .items          (items),
        .score          (score)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        r_checks++;
        if (actual !== expected) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic collect_pulse();
        collect_item = 1'b1;
        tick();
        collect_item = 1'b0;
        tick();
    endtask

    task automatic prep(input logic [1:0] sel);
        game_state     = 4'd1;
        selector_value = sel;
        tick();
        game_state = 4'd2;
        tick();
    endtask

    initial begin
        reset = 1'b1; game_state = 4'd0; selector_value = 2'd0;
        frame_tick = 1'b0; reached_goal = 1'b0; hit_hazard = 1'b0; collect_item = 1'b0;
        tickn(2);
        check_val("rst_win",   32'(win_the_game),  0);
        check_val("rst_lose",  32'(lose_the_game), 0);
        check_val("rst_time",  32'(time_left),     0);
        check_val("rst_items", 32'(items),         0);
        check_val("rst_score", 32'(score),         0);
        reset = 1'b0;

        // 1: timeout on level 0
        game_state = 4'd1; selector_value = 2'd0;
        tick();
        check_val("prep0_time",  32'(time_left), 600);
        check_val("prep0_score", 32'(score),     0);
        game_state = 4'd2;
        tick();
        frame_tick = 1'b1;
        tickn(600);
        frame_tick = 1'b0;
        check_val("timeout_time",     32'(time_left),     0);
        check_val("timeout_lose_pre", 32'(lose_the_game), 0);
        tick();
        check_val("timeout_lose", 32'(lose_the_game), 1);
        check_val("timeout_win",  32'(win_the_game),  0);
        tickn(3);
        check_val("lose_held", 32'(lose_the_game), 1);
        game_state = 4'd1;
        tick();
        check_val("lose_ack",  32'(lose_the_game), 0);
        check_val("ack_time0", 32'(time_left),     600);

        // 2: level 0 win with held collects
        game_state = 4'd2;
        tick();
        for (int k = 0; k < 3; k++) begin
            collect_item = 1'b1;
            tickn(5);
            collect_item = 1'b0;
            tick();
        end
        check_val("l0_items", 32'(items), 3);
        check_val("l0_score", 32'(score), 30);
        frame_tick = 1'b1;
        tickn(200);
        frame_tick = 1'b0;
        check_val("l0_time400", 32'(time_left), 400);
        reached_goal = 1'b1;
        tick();
        reached_goal = 1'b0;
        check_val("l0_win",       32'(win_the_game), 1);
        check_val("l0_win_score", 32'(score),        430);
        tick();
        check_val("win_held", 32'(win_the_game), 1);
        game_state = 4'd3;
        tick();
        check_val("win_ack_gs3",  32'(win_the_game), 0);
        check_val("gs3_score",    32'(score),        430);
        game_state = 4'd1; selector_value = 2'd1;
        tick();
        check_val("prep1_time", 32'(time_left),    900);
        check_val("prep1_win",  32'(win_the_game), 0);

        // 3: goal short of items, then hazard+goal together
        prep(2'd0);
        collect_pulse();
        collect_pulse();
        reached_goal = 1'b1;
        tick();
        reached_goal = 1'b0;
        check_val("short_goal_win", 32'(win_the_game), 0);
        check_val("short_items",    32'(items),        2);
        collect_pulse();
        check_val("l0b_score", 32'(score), 460);
        hit_hazard = 1'b1; reached_goal = 1'b1;
        tick();
        hit_hazard = 1'b0; reached_goal = 1'b0;
        check_val("both_lose",  32'(lose_the_game), 1);
        check_val("both_win",   32'(win_the_game),  0);
        check_val("both_score", 32'(score),         430);

        // 4: level 1 loss restores snapshot
        prep(2'd1);
        for (int k = 0; k < 6; k++) collect_pulse();
        check_val("l1_score", 32'(score), 490);
        hit_hazard = 1'b1;
        tick();
        hit_hazard = 1'b0;
        check_val("l1_lose_score", 32'(score), 430);
        game_state = 4'd1;
        tick();
        check_val("retry_score", 32'(score),     430);
        check_val("retry_time",  32'(time_left), 900);

        // 5: score and item saturation via repeated level 1 wins
        for (int r = 0; r < 69; r++) begin
            prep(2'd1);
            for (int k = 0; k < 5; k++) collect_pulse();
            reached_goal = 1'b1;
            tick();
            reached_goal = 1'b0;
            if (r == 67) check_val("score_65030", 32'(score), 65030);
        end
        check_val("score_sat_bonus", 32'(score), 65535);
        prep(2'd1);
        collect_pulse();
        check_val("score_sat_item", 32'(score), 65535);
        for (int k = 0; k < 15; k++) collect_pulse();
        check_val("items_sat", 32'(items), 15);
        reached_goal = 1'b1;
        tick();
        reached_goal = 1'b0;
        check_val("sat_win", 32'(win_the_game), 1);

        // 6: reset mid-play with win pending, then START clears score
        prep(2'd0);
        for (int k = 0; k < 3; k++) collect_pulse();
        reached_goal = 1'b1; reset = 1'b1;
        tick();
        reached_goal = 1'b0;
        check_val("midrst_win",   32'(win_the_game), 0);
        check_val("midrst_score", 32'(score),        0);
        check_val("midrst_items", 32'(items),        0);
        check_val("midrst_time",  32'(time_left),    0);
        game_state = 4'd1; selector_value = 2'd0; reset = 1'b0;
        tick();
        game_state = 4'd2;
        tick();
        for (int k = 0; k < 3; k++) collect_pulse();
        reached_goal = 1'b1;
        tick();
        reached_goal = 1'b0;
        check_val("post_rst_win",   32'(win_the_game), 1);
        check_val("post_rst_score", 32'(score),        630);
        game_state = 4'd0;
        tick();
        check_val("start_score", 32'(score),        0);
        check_val("start_items", 32'(items),        0);
        check_val("start_win",   32'(win_the_game), 0);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule : tb_level_referee
`default_nettype wire
